sseg_scan: RTL
==============

# sseg_scan

Parametrised multiplexed seven-segment scanner: the next generation of the team's 8-digit hex display driver. Drives `DIGITS` common-anode digits from a double-buffered hex/decimal-point image, adding per-digit blink masks, leading-zero blanking, PWM brightness, and tear-free frame-synchronous updates via a load handshake. Sits between any status or debug register source and the board's active-low anode and segment pins.

## Interface
- `DIGITS`, 8: number of digits, 1..16.
- `TICK_LOG2`, 16: log2 of clock cycles per digit slot.
- `PWM_BITS`, 4: brightness resolution, 1..`TICK_LOG2`.
- `BLINK_DIV`, 50000000: clock cycles per blink half-period, ≥2.

Ports:
- `clk`  in  1  system clock; sole clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `en`  in  1  display enable; 0 blanks the outputs, counters keep running.
- `ld`  in  1  load strobe; accepted only when `rdy`=1.
- `ld_dat`  in  4*DIGITS  nibble i drives digit i; digit 0 is rightmost.
- `ld_dp`  in  DIGITS  decimal point per digit, 1 = lit.
- `ld_blk`  in  DIGITS  blink mask per digit, 1 = blinks.
- `lzb`  in  1  leading-zero blanking enable; live, not buffered.
- `bright`  in  PWM_BITS  brightness; live, not buffered.
- `rdy`  out  1  shadow buffer free.
- `frm`  out  1  one-cycle pulse at each frame boundary.
- `an`  out  DIGITS  anodes, active-low, registered.
- `seg`  out  8  segments, active-low, registered; `seg[7]` is dp, `seg[6:0]` is gfedcba.

## Operation
- Tick counter `tc` (`TICK_LOG2` bits) free-runs. Digit index `di` advances when `tc` is all ones and wraps from DIGITS-1 to 0.
- Frame boundary: `tc` all ones and `di`=DIGITS-1. `frm`=1 in the following cycle.
- Blink counter counts 0..BLINK_DIV-1. On reaching BLINK_DIV-1 it clears and toggles phase `bp`. `bp` resets to 1 (visible).
- Digit i is blanked when any of the following holds:
  - `en`=0;
  - `ld_blk` active bit i =1 and `bp`=0;
  - `lzb`=1, i≠0, and all active nibbles i..DIGITS-1 are zero;
  - PWM off: `tc[TICK_LOG2-1 -: PWM_BITS]` > `bright`.
- Digit 0 is never blanked by `lzb`. With `bright` all ones, duty is 100%; with `bright`=0, duty is 1/2^PWM_BITS.
- Unblanked digit: `an` bit `di`=0, all other bits 1; `seg[6:0]`=decode(nibble `di`), `seg[7]`=~dp.
- Blanked digit: `an`=all ones, `seg`=8'hff.
- Decode (hex, 8-bit incl. dp off): 0:c0 1:f9 2:a4 3:b0 4:99 5:92 6:82 7:f8 8:80 9:98 a:88 b:83 c:c6 d:a1 e:86 f:8e.
- Handshake:
  - `ld`&`rdy`: capture `ld_dat`/`ld_dp`/`ld_blk` into the shadow buffer; `rdy`=0 from the next cycle.
  - At the next frame boundary with the shadow full: copy shadow to active; `rdy`=1 from the next cycle.
  - `ld` while `rdy`=0 is ignored (no overwrite).
  - `ld` accepted in the boundary cycle itself: the transfer waits for the following boundary.
- Reset: all counters 0, `di`=0, `bp`=1, shadow empty, active image zero, `rdy`=1, `frm`=0, `an`=all ones, `seg`=8'hff. The first frame boundary after reset occurs at cycle DIGITS·2^TICK_LOG2 − 1.

## Timing
- `an`/`seg`/`frm` are registered: they reflect `tc`/`di`/`bp` and the active image from the prior cycle (latency 1).
- Digit slot lasts 2^TICK_LOG2 cycles; a frame lasts DIGITS·2^TICK_LOG2 cycles.
- Minimum load-to-display latency: 1 cycle (capture) + wait to boundary + 1 cycle (transfer) + 1 cycle (output register). Maximum: one full frame + 3 cycles.
- Reset mid-frame takes effect in the next cycle and discards a pending shadow.
- `en`, `lzb`, and `bright` changes show on the outputs with 1-cycle latency.

## Structure
- Package `sseg_pkg`: hex-to-segment constant table/function, `SEG_BLANK`=8'hff, `AN_OFF` helper.
- Sub-module `sseg_dec`: combinational nibble+dp → 8-bit active-low segment decoder, reusable by other display blocks.
- Remaining logic (counters, buffers, blanking, output registers) stays flat in `sseg_scan`.

## Test plan
Bench parameters: DIGITS=4, TICK_LOG2=2, PWM_BITS=2, BLINK_DIV=16.
- Reset release, no load → `an`=4'hf, `seg`=8'hff, `rdy`=1; first `frm` pulse at cycle 16.
- Load `ld_dat`=16'h1a2f, `bright`=3, `lzb`=0 → after next boundary each 4-cycle slot shows `an`=e/d/b/7 with `seg`=8e/a4/88/f9; `rdy` low until the transfer.
- `ld_dat`=16'h0030, `lzb`=1 → digits 3 and 2 blanked (`an` bit high, `seg`=ff); digit 1 shows b0; digit 0 shows c0.
- `bright`=1 → each slot drives its anode for 2 of 4 cycles, then `an`=all ones.
- `ld_blk`=4'b0010 → digit 1 is dark for 16 cycles, then lit for 16, repeating; other digits are unaffected.
- Second `ld` while `rdy`=0 → ignored; `ld` on the boundary cycle → transfer at the following boundary; `rst_n`=0 mid-frame → outputs ff/all ones next cycle, `rdy`=1.

Source files
------------

// File: rtl/sseg_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | sseg_pkg : segment decode table and anode helpers for 7-seg displays     |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
package sseg_pkg;

  localparam int unsigned       MAX_DIGITS = 16;
  localparam logic [7:0]        SEG_BLANK  = 8'hff;
  localparam logic [15:0]       AN_OFF     = 16'hffff;

  // Active-low gfedcba; prepend 1'b1 for the 8-bit form with the dp dark.
  function automatic logic [6:0] hex2seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h18;
      4'ha: s = 7'h08;
      4'hb: s = 7'h03;
      4'hc: s = 7'h46;
      4'hd: s = 7'h21;
      4'he: s = 7'h06;
      default: s = 7'h0e;
    endcase
    return s;
  endfunction

  function automatic logic [MAX_DIGITS-1:0] an_sel(input logic [3:0] idx);
    return ~(MAX_DIGITS'(1) << idx);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sseg_dec.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | sseg_dec : nibble + decimal point to active-low 8-bit segment pattern    |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module sseg_dec
  import sseg_pkg::*;
(
  input  logic [3:0] nib_i,
  input  logic       dp_i,
  output logic [7:0] seg_o
);

  assign seg_o = {~dp_i, hex2seg(nib_i)};

endmodule
`default_nettype wire

// File: rtl/sseg_scan.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | sseg_scan : double-buffered multiplexed 7-seg scanner, blink/LZB/PWM     |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module sseg_scan
  import sseg_pkg::*;
#(
  parameter int unsigned DIGITS    = 8,
  parameter int unsigned TICK_LOG2 = 16,
  parameter int unsigned PWM_BITS  = 4,
  parameter int unsigned BLINK_DIV = 50000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  ld,
  input  logic [4*DIGITS-1:0]   ld_dat,
  input  logic [DIGITS-1:0]     ld_dp,
  input  logic [DIGITS-1:0]     ld_blk,
  input  logic                  lzb,
  input  logic [PWM_BITS-1:0]   bright,
  output logic                  rdy,
  output logic                  frm,
  output logic [DIGITS-1:0]     an,
  output logic [7:0]            seg
);

  localparam int unsigned     DI_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned     BC_W    = $clog2(BLINK_DIV);
  localparam logic [DI_W-1:0] DI_LAST = DI_W'(DIGITS - 1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(BLINK_DIV - 1);

  logic [TICK_LOG2-1:0]     tc_q;
  logic [DI_W-1:0]          di_q;
  logic [BC_W-1:0]          bc_q;
  logic                     bp_q;
  logic                     frm_q;

  logic                     sh_full_q;
  logic [DIGITS-1:0][3:0]   sh_dat_q;
  logic [DIGITS-1:0]        sh_dp_q;
  logic [DIGITS-1:0]        sh_blk_q;

  logic [DIGITS-1:0][3:0]   act_dat_q;
  logic [DIGITS-1:0]        act_dp_q;
  logic [DIGITS-1:0]        act_blk_q;

  logic [DIGITS-1:0]        an_q, an_d;
  logic [7:0]               seg_q, seg_d;

  logic                     tick_end;
  logic                     frame_end;
  logic [DIGITS-1:0]        lz_mask;
  logic                     lz_run;
  logic [3:0]               cur_nib;
  logic                     cur_dp;
  logic                     cur_blk;
  logic                     pwm_off;
  logic                     blank;
  logic [7:0]               dec_seg;
  logic [MAX_DIGITS-1:0]    an_full;

  assign tick_end  = &tc_q;
  assign frame_end = tick_end && (di_q == DI_LAST);

  assign cur_nib = act_dat_q[di_q];
  assign cur_dp  = act_dp_q[di_q];
  assign cur_blk = act_blk_q[di_q];
  assign pwm_off = tc_q[TICK_LOG2-1 -: PWM_BITS] > bright;

  // lz_mask[i] is set when every active nibble from i up to the top is zero.
  always_comb begin
    lz_run  = 1'b1;
    lz_mask = '0;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      lz_run     = lz_run & (act_dat_q[i] == 4'h0);
      lz_mask[i] = lz_run;
    end
  end

  assign blank = !en
              || (cur_blk && !bp_q)
              || (lzb && (di_q != '0) && lz_mask[di_q])
              || pwm_off;

  sseg_dec u_dec (
    .nib_i (cur_nib),
    .dp_i  (cur_dp),
    .seg_o (dec_seg)
  );

  always_comb begin
    an_full = blank ? AN_OFF : an_sel(4'(di_q));
    an_d    = an_full[DIGITS-1:0];
    seg_d   = blank ? SEG_BLANK : dec_seg;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tc_q      <= '0;
      di_q      <= '0;
      bc_q      <= '0;
      bp_q      <= 1'b1;
      frm_q     <= 1'b0;
      sh_full_q <= 1'b0;
      sh_dat_q  <= '0;
      sh_dp_q   <= '0;
      sh_blk_q  <= '0;
      act_dat_q <= '0;
      act_dp_q  <= '0;
      act_blk_q <= '0;
      an_q      <= '1;
      seg_q     <= SEG_BLANK;
    end else begin
      tc_q <= tc_q + TICK_LOG2'(1);
      if (tick_end) begin
        di_q <= (di_q == DI_LAST) ? '0 : di_q + DI_W'(1);
      end

      if (bc_q == BC_LAST) begin
        bc_q <= '0;
        bp_q <= ~bp_q;
      end else begin
        bc_q <= bc_q + BC_W'(1);
      end

      frm_q <= frame_end;

      // Capture and transfer are exclusive: one needs an empty shadow, the other a full one.
      if (ld && !sh_full_q) begin
        sh_dat_q  <= ld_dat;
        sh_dp_q   <= ld_dp;
        sh_blk_q  <= ld_blk;
        sh_full_q <= 1'b1;
      end else if (frame_end && sh_full_q) begin
        act_dat_q <= sh_dat_q;
        act_dp_q  <= sh_dp_q;
        act_blk_q <= sh_blk_q;
        sh_full_q <= 1'b0;
      end

      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign rdy = ~sh_full_q;
  assign frm = frm_q;
  assign an  = an_q;
  assign seg = seg_q;

endmodule
`default_nettype wire
